// File: rtl/timer_pkg.sv
// Shared register map, TCON bit positions and address decode for the irq_timer peripheral.
package timer_pkg;

   localparam logic [7:0] OFS_TH      = 8'h00;
   localparam logic [7:0] OFS_TL      = 8'h04;
   localparam logic [7:0] OFS_TCON    = 8'h08;
   localparam logic [7:0] OFS_PSC     = 8'h0C;
   localparam logic [7:0] OFS_SYSTICK = 8'h14;

   localparam int unsigned TCON_EN = 0;
   localparam int unsigned TCON_IE = 1;
   localparam int unsigned TCON_IF = 2;

   localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_TH,
      REG_TL,
      REG_TCON,
      REG_PSC,
      REG_SYSTICK
   } reg_sel_e;

   function automatic reg_sel_e decode_reg(input logic [7:0] rel);
      reg_sel_e sel;
      case (rel)
         OFS_TH:      sel = REG_TH;
         OFS_TL:      sel = REG_TL;
         OFS_TCON:    sel = REG_TCON;
         OFS_PSC:     sel = REG_PSC;
         OFS_SYSTICK: sel = REG_SYSTICK;
         default:     sel = REG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider for irq_timer: counts 0..psc while enabled, ticks on the terminal count.
module timer_prescaler #(
   parameter int unsigned PSC_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [PSC_W-1:0] psc,
   input  logic             clr,
   output logic             tick
);

   logic [PSC_W-1:0] count;
   logic             terminal;

   assign terminal = (count == psc);
   // A PSC write restarts the period, so the old terminal count must not tick.
   assign tick     = en & ~clr & terminal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (!en || clr || terminal) begin
         count <= '0;
      end else begin
         count <= count + PSC_W'(1);
      end
   end

endmodule

// File: rtl/irq_timer.sv
// Memory-mapped reload timer with level interrupt and free-running SYSTICK.
// Optional prescaler enabled by defining TIMER_PRESCALER_EN.
module irq_timer
   import timer_pkg::*;
#(
   parameter logic [7:0]  BASE_OFS = 8'h00,
   parameter int unsigned PSC_W    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irqout
);

   logic [7:0]  rel_ofs;
   reg_sel_e    sel;
   logic        wr_th, wr_tl, wr_tcon;
   logic [31:0] th, tl, systick;
   logic        en, ie, iflag;
   logic        tick, ovf;
   logic        unused_addr;

   assign rel_ofs     = {addr[7:2], 2'b00} - BASE_OFS;
   assign sel         = decode_reg(rel_ofs);
   assign wr_th       = wr & (sel == REG_TH);
   assign wr_tl       = wr & (sel == REG_TL);
   assign wr_tcon     = wr & (sel == REG_TCON);
   assign unused_addr = &{1'b0, addr[31:8], addr[1:0]};

`ifdef TIMER_PRESCALER_EN
   logic [PSC_W-1:0] psc;
   logic             wr_psc;

   assign wr_psc = wr & (sel == REG_PSC);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         psc <= '0;
      end else if (wr_psc) begin
         psc <= wdata[PSC_W-1:0];
      end
   end

   timer_prescaler #(.PSC_W(PSC_W)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .psc   (psc),
      .clr   (wr_psc),
      .tick  (tick)
   );
`else
   localparam int unsigned UNUSED_PSC_W = PSC_W;

   assign tick = en;
`endif

   // A CPU write to TL drops the concurrent tick, so it can neither reload nor raise IF.
   assign ovf    = tick & ~wr_tl & (tl == TL_MAX);
   assign irqout = ie & iflag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th      <= '0;
         tl      <= '0;
         en      <= 1'b0;
         ie      <= 1'b0;
         iflag   <= 1'b0;
         systick <= '0;
      end else begin
         systick <= systick + 32'd1;

         if (wr_th) begin
            th <= wdata;
         end

         if (wr_tl) begin
            tl <= wdata;
         end else if (ovf) begin
            tl <= th;
         end else if (tick) begin
            tl <= tl + 32'd1;
         end

         if (wr_tcon) begin
            en    <= wdata[TCON_EN];
            ie    <= wdata[TCON_IE];
            iflag <= wdata[TCON_IF] | (ovf & wdata[TCON_IE]);
         end else if (ovf & ie) begin
            iflag <= 1'b1;
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (rd) begin
         case (sel)
            REG_TH:      rdata = th;
            REG_TL:      rdata = tl;
            REG_TCON: begin
               rdata[TCON_EN] = en;
               rdata[TCON_IE] = ie;
               rdata[TCON_IF] = iflag;
            end
`ifdef TIMER_PRESCALER_EN
            REG_PSC:     rdata[PSC_W-1:0] = psc;
`endif
            REG_SYSTICK: rdata = systick;
            default:     rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_timer.sv
// Self-checking bench for irq_timer: directed scenarios plus randomized traffic vs a register-level model.
`timescale 1ns/1ps
module tb_irq_timer;

   localparam logic [31:0] A_BASE = 32'h4000_0000;
   localparam logic [31:0] A_TH   = A_BASE + 32'h00;
   localparam logic [31:0] A_TL   = A_BASE + 32'h04;
   localparam logic [31:0] A_TCON = A_BASE + 32'h08;
   localparam logic [31:0] A_PSC  = A_BASE + 32'h0C;
   localparam logic [31:0] A_SYS  = A_BASE + 32'h14;

`ifdef TIMER_PRESCALER_EN
   localparam bit HAS_PSC = 1'b1;
`else
   localparam bit HAS_PSC = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd, wr;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        irqout;

   // Register-level reference state.
   logic [31:0] m_th, m_tl, m_sys;
   bit          m_en, m_ie, m_if;
   int unsigned m_psc, m_pcnt;

   always #10 clk = ~clk;

   irq_timer #(.BASE_OFS(8'h00), .PSC_W(16)) dut (
      .clk    (clk),
      .reset  (reset),
      .rd     (rd),
      .wr     (wr),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .irqout (irqout)
   );

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation still running at %0t, limit 5000000", $time);
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      m_th = '0; m_tl = '0; m_sys = '0;
      m_en = 0; m_ie = 0; m_if = 0;
      m_psc = 0; m_pcnt = 0;
   endtask

   function automatic int unsigned word_ofs(input logic [31:0] a);
      return {24'h0, a[7:2], 2'b00};
   endfunction

   task automatic model_clock(input bit w, input logic [31:0] a, input logic [31:0] d);
      int unsigned ofs;
      bit w_th, w_tl, w_tc, w_ps, tick, ovf;
      ofs  = word_ofs(a);
      w_th = w && ofs == 0;
      w_tl = w && ofs == 4;
      w_tc = w && ofs == 8;
      w_ps = w && HAS_PSC && ofs == 12;
      if (HAS_PSC) tick = m_en && !w_ps && m_pcnt == m_psc;
      else         tick = m_en;
      ovf = tick && !w_tl && m_tl == 32'hFFFF_FFFF;
      if (w_tl)      m_tl = d;
      else if (ovf)  m_tl = m_th;
      else if (tick) m_tl = m_tl + 1;
      if (!m_en || w_ps || m_pcnt == m_psc) m_pcnt = 0;
      else m_pcnt = m_pcnt + 1;
      if (w_ps) m_psc = d & 32'hFFFF;
      if (w_tc) begin
         m_if = d[2] | (ovf & d[1]);
         m_en = d[0];
         m_ie = d[1];
      end else if (ovf && m_ie) begin
         m_if = 1;
      end
      if (w_th) m_th = d;
      m_sys = m_sys + 1;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      case (word_ofs(a))
         0:       return m_th;
         4:       return m_tl;
         8:       return {29'h0, m_if, m_ie, m_en};
         12:      return HAS_PSC ? m_psc : 32'h0;
         20:      return m_sys;
         default: return 32'h0;
      endcase
   endfunction

   // Called at a negedge; leaves the bench at the following negedge.
   task automatic step(input bit w, input logic [31:0] a, input logic [31:0] d);
      wr = w; addr = a; wdata = d;
      @(posedge clk);
      model_clock(w, a, d);
      @(negedge clk);
      wr = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, A_BASE, 32'h0);
   endtask

   task automatic rd_reg(input logic [31:0] a, output logic [31:0] v);
      rd = 1; addr = a;
      #1;
      v = rdata;
      rd = 0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      logic [31:0] regs [5];
      reset = 1; rd = 0; wr = 0; addr = A_BASE; wdata = 0;
      model_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (irqout !== 1'b0) begin errors++; $display("FAIL rst_irq_init: got %b exp 0", irqout); end
      reset = 0;
      step(1, A_TH, 32'h1234);
      step(1, A_TL, 32'hFFFF_FFFE);
      step(1, A_TCON, 32'h3);
      idle(2);
      checks++;
      if (irqout !== 1'b1) begin errors++; $display("FAIL rst_pre_irq: got %b exp 1", irqout); end
      #2 reset = 1;
      #1;
      checks++;
      if (irqout !== 1'b0) begin errors++; $display("FAIL rst_async_irq: got %b exp 0", irqout); end
      @(negedge clk);
      reset = 0;
      model_reset();
      regs = '{A_TH, A_TL, A_TCON, A_PSC, A_SYS};
      foreach (regs[i]) begin
         rd_reg(regs[i], v);
         checks++;
         if (v !== 32'h0) begin errors++; $display("FAIL rst_reg%0d: got %h exp 00000000", i, v); end
      end
   endtask

   task automatic test_reload();
      logic [31:0] v;
      logic [31:0] exp_tl [3];
      exp_tl = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      step(1, A_TH, 32'hFFFF_FFFD);
      step(1, A_TL, 32'hFFFF_FFFD);
      step(1, A_TCON, 32'h3);
      rd_reg(A_TL, v);
      checks++;
      if (v !== 32'hFFFF_FFFD) begin errors++; $display("FAIL reload_start: got %h exp fffffffd", v); end
      foreach (exp_tl[i]) begin
         idle(1);
         rd_reg(A_TL, v);
         checks++;
         if (v !== exp_tl[i]) begin errors++; $display("FAIL reload_tl%0d: got %h exp %h", i, v, exp_tl[i]); end
         checks++;
         if (irqout !== (i == 2)) begin errors++; $display("FAIL reload_irq%0d: got %b exp %b", i, irqout, i == 2); end
      end
      rd_reg(A_TCON, v);
      checks++;
      if (v !== 32'h7) begin errors++; $display("FAIL reload_tcon: got %h exp 00000007", v); end
   endtask

   task automatic test_clear_if();
      logic [31:0] v, v0;
      step(1, A_TCON, 32'h3);
      checks++;
      if (irqout !== 1'b0) begin errors++; $display("FAIL clrif_irq: got %b exp 0", irqout); end
      rd_reg(A_TL, v);
      checks++;
      if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL clrif_run1: got %h exp fffffffe", v); end
      idle(1);
      rd_reg(A_TL, v);
      checks++;
      if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL clrif_run2: got %h exp ffffffff", v); end
      step(1, A_TCON, 32'h2);
      rd_reg(A_TL, v0);
      idle(3);
      rd_reg(A_TL, v);
      checks++;
      if (v !== v0 || v !== 32'hFFFF_FFFD) begin errors++; $display("FAIL freeze_tl: got %h exp fffffffd", v); end
      step(1, A_TCON, 32'h0);
   endtask

   task automatic test_collision();
      logic [31:0] v;
      step(1, A_TH, 32'h10);
      step(1, A_TL, 32'hFFFF_FFFE);
      step(1, A_TCON, 32'h1);
      idle(1);
      step(1, A_TCON, 32'h3);
      rd_reg(A_TCON, v);
      checks++;
      if (v !== 32'h7) begin errors++; $display("FAIL col_tcon_if: got %h exp 00000007", v); end
      checks++;
      if (irqout !== 1'b1) begin errors++; $display("FAIL col_tcon_irq: got %b exp 1", irqout); end
      rd_reg(A_TL, v);
      checks++;
      if (v !== 32'h10) begin errors++; $display("FAIL col_tcon_tl: got %h exp 00000010", v); end

      step(1, A_TCON, 32'h0);
      step(1, A_TL, 32'hFFFF_FFFE);
      step(1, A_TCON, 32'h3);
      idle(1);
      step(1, A_TL, 32'h5);
      rd_reg(A_TL, v);
      checks++;
      if (v !== 32'h5) begin errors++; $display("FAIL col_tl_val: got %h exp 00000005", v); end
      rd_reg(A_TCON, v);
      checks++;
      if (v !== 32'h3) begin errors++; $display("FAIL col_tl_if: got %h exp 00000003", v); end

      step(1, A_TCON, 32'h0);
      step(1, A_TH, 32'h10);
      step(1, A_TL, 32'hFFFF_FFFE);
      step(1, A_TCON, 32'h1);
      idle(1);
      step(1, A_TH, 32'h20);
      rd_reg(A_TL, v);
      checks++;
      if (v !== 32'h10) begin errors++; $display("FAIL col_th_old: got %h exp 00000010", v); end
      step(1, A_TL, 32'hFFFF_FFFF);
      idle(1);
      rd_reg(A_TL, v);
      checks++;
      if (v !== 32'h20) begin errors++; $display("FAIL col_th_new: got %h exp 00000020", v); end
      step(1, A_TCON, 32'h0);
   endtask

   task automatic test_decode();
      logic [31:0] v, s0, s1;
      step(1, A_TL, 32'h1234);
      rd_reg(A_BASE + 32'h10, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL dec_10: got %h exp 00000000", v); end
      rd_reg(A_BASE + 32'h18, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL dec_18: got %h exp 00000000", v); end
      rd_reg(A_BASE + 32'h07, v);
      checks++;
      if (v !== 32'h1234) begin errors++; $display("FAIL dec_lowbits: got %h exp 00001234", v); end
      rd = 0; addr = A_TL; #1;
      checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL dec_nord: got %h exp 00000000", rdata); end
      rd_reg(A_SYS, s0);
      checks++;
      if (s0 !== m_sys) begin errors++; $display("FAIL sys_abs: got %h exp %h", s0, m_sys); end
      step(1, A_SYS, 32'hDEAD_0000);
      rd_reg(A_SYS, v);
      checks++;
      if (v !== s0 + 32'd1) begin errors++; $display("FAIL sys_wr_ignored: got %h exp %h", v, s0 + 32'd1); end
      rd_reg(A_SYS, s1);
      idle(100);
      rd_reg(A_SYS, v);
      checks++;
      if (v - s1 !== 32'd100) begin errors++; $display("FAIL sys_delta: got %0d exp 100", v - s1); end
   endtask

   task automatic test_prescaler();
      logic [31:0] v, exp;
      step(1, A_TCON, 32'h0);
      step(1, A_TL, 32'h0);
      step(1, A_PSC, 32'h3);
      rd_reg(A_PSC, v);
      exp = HAS_PSC ? 32'h3 : 32'h0;
      checks++;
      if (v !== exp) begin errors++; $display("FAIL psc_read: got %h exp %h", v, exp); end
      step(1, A_TCON, 32'h1);
      for (int i = 1; i <= 8; i++) begin
         idle(1);
         rd_reg(A_TL, v);
         exp = HAS_PSC ? i / 4 : i;
         checks++;
         if (v !== exp) begin errors++; $display("FAIL psc_tl%0d: got %h exp %h", i, v, exp); end
      end
      step(1, A_TCON, 32'h0);
      step(1, A_PSC, 32'h0);
   endtask

   task automatic test_random();
      logic [31:0] v, a, d;
      logic [31:0] unmapped [4];
      int unsigned op;
      unmapped = '{32'h10, 32'h14, 32'h18, 32'h1C};
      for (int n = 0; n < 400; n++) begin
         op = $urandom_range(0, 9);
         a  = A_BASE | $urandom_range(0, 3);
         d  = $urandom;
         case (op)
            0, 1: step(1, a | 32'h04, 32'hFFFF_FFF8 + $urandom_range(0, 7));
            2:    step(1, a | 32'h00, d);
            3:    step(1, a | 32'h08, d & 32'h7);
            4:    step(1, a | 32'h0C, $urandom_range(0, 3));
            5:    step(1, a | unmapped[$urandom_range(0, 3)], d);
            default: step(0, a, d);
         endcase
         checks++;
         if (irqout !== (m_ie & m_if)) begin errors++; $display("FAIL rnd_irq[%0d]: got %b exp %b", n, irqout, m_ie & m_if); end
         rd_reg(A_TL, v);
         checks++;
         if (v !== model_read(A_TL)) begin errors++; $display("FAIL rnd_tl[%0d]: got %h exp %h", n, v, model_read(A_TL)); end
         rd_reg(A_TCON, v);
         checks++;
         if (v !== model_read(A_TCON)) begin errors++; $display("FAIL rnd_tcon[%0d]: got %h exp %h", n, v, model_read(A_TCON)); end
         if (n % 50 == 0) begin
            rd_reg(A_SYS, v);
            checks++;
            if (v !== model_read(A_SYS)) begin errors++; $display("FAIL rnd_sys[%0d]: got %h exp %h", n, v, model_read(A_SYS)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_reload();
      test_clear_if();
      test_collision();
      test_decode();
      test_prescaler();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
